// File: rtl/regincr_pipe.sv
// regincr_pipe: NSTAGES-deep val/rdy pipeline in which every stage adds INCR, so out = in + NSTAGES*INCR.
// Define REGINCR_PIPE_SAT_EN to make each stage saturate at all-ones instead of wrapping.
module regincr_pipe #(
  parameter int NBITS   = 8,
  parameter int NSTAGES = 2,
  parameter int INCR    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [NBITS-1:0]             in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [NBITS-1:0]             out_msg,
  output logic                         out_ovf,
  output logic [$clog2(NSTAGES+1)-1:0] occupancy
);

  localparam int              OCCW     = $clog2(NSTAGES+1);
  localparam logic [NBITS:0]  INCR_EXT = (NBITS+1)'(INCR);

  logic [NSTAGES-1:0] r_val;
  logic [NSTAGES-1:0] r_ovf;
  logic [NBITS-1:0]   r_msg     [NSTAGES];

  logic [NSTAGES-1:0] w_rdy;
  logic [NSTAGES-1:0] w_upVal;
  logic [NSTAGES-1:0] w_upOvf;
  logic [NSTAGES-1:0] w_nextOvf;
  logic [NBITS-1:0]   w_upMsg   [NSTAGES];
  logic [NBITS-1:0]   w_nextMsg [NSTAGES];
  logic [OCCW-1:0]    w_occ;

  // An empty stage always accepts, so bubbles collapse even while the output is stalled.
  always_comb begin
    w_rdy = '0;
    w_rdy[NSTAGES-1] = ~r_val[NSTAGES-1] | out_rdy;
    for (int i = NSTAGES-2; i >= 0; i--)
      w_rdy[i] = ~r_val[i] | w_rdy[i+1];
  end

  for (genvar g = 0; g < NSTAGES; g++) begin : gStage
    logic [NBITS:0] w_sum;

    if (g == 0) begin : gFirst
      assign w_upVal[g] = in_val;
      assign w_upMsg[g] = in_msg;
      assign w_upOvf[g] = 1'b0;
    end else begin : gRest
      assign w_upVal[g] = r_val[g-1];
      assign w_upMsg[g] = r_msg[g-1];
      assign w_upOvf[g] = r_ovf[g-1];
    end

    assign w_sum = {1'b0, w_upMsg[g]} + INCR_EXT;

`ifdef REGINCR_PIPE_SAT_EN
    assign w_nextMsg[g] = w_sum[NBITS] ? '1 : w_sum[NBITS-1:0];
`else
    assign w_nextMsg[g] = w_sum[NBITS-1:0];
`endif
    assign w_nextOvf[g] = w_upOvf[g] | w_sum[NBITS];
  end

  // Message and flag are only captured alongside a valid token; a stalled stage holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val <= '0;
      r_ovf <= '0;
      for (int i = 0; i < NSTAGES; i++)
        r_msg[i] <= '0;
    end else begin
      for (int i = 0; i < NSTAGES; i++) begin
        if (w_rdy[i]) begin
          r_val[i] <= w_upVal[i];
          if (w_upVal[i]) begin
            r_msg[i] <= w_nextMsg[i];
            r_ovf[i] <= w_nextOvf[i];
          end
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NSTAGES; i++)
      w_occ = w_occ + OCCW'(r_val[i]);
  end

  assign in_rdy    = w_rdy[0] & ~reset;
  assign out_val   = r_val[NSTAGES-1];
  assign out_msg   = r_msg[NSTAGES-1];
  assign out_ovf   = r_ovf[NSTAGES-1];
  assign occupancy = w_occ;

endmodule

// File: tb/tb_regincr_pipe.sv
// Testbench for regincr_pipe: directed and random val/rdy traffic scored against an arithmetic
// reference model through an expectation queue; a second NSTAGES=4, INCR=3 instance covers deep pipes.
module tb_regincr_pipe;

  localparam int NB   = 8;
  localparam int NS   = 2;
  localparam int INC  = 1;
  localparam int NS4  = 4;
  localparam int INC4 = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_val = 1'b0;
  logic                     in_rdy;
  logic [NB-1:0]            in_msg = '0;
  logic                     out_val;
  logic                     out_rdy = 1'b1;
  logic [NB-1:0]            out_msg;
  logic                     out_ovf;
  logic [$clog2(NS+1)-1:0]  occupancy;

  logic                     in_val4 = 1'b0;
  logic                     in_rdy4;
  logic [NB-1:0]            in_msg4 = '0;
  logic                     out_val4;
  logic                     out_rdy4 = 1'b1;
  logic [NB-1:0]            out_msg4;
  logic                     out_ovf4;
  logic [$clog2(NS4+1)-1:0] occupancy4;

  typedef struct {
    logic [NB-1:0] msg;
    logic          ovf;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cycle   = 0;
  int   inCnt   = 0;
  int   outCnt  = 0;
  bit   chkLat  = 1'b0;
  bit   holdValid = 1'b0;
  logic [NB-1:0] holdMsg = '0;
  logic          holdOvf = 1'b0;

  regincr_pipe #(.NBITS(NB), .NSTAGES(NS), .INCR(INC)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_ovf(out_ovf), .occupancy(occupancy)
  );

  regincr_pipe #(.NBITS(NB), .NSTAGES(NS4), .INCR(INC4)) dut4 (
    .clk(clk), .reset(reset),
    .in_val(in_val4), .in_rdy(in_rdy4), .in_msg(in_msg4),
    .out_val(out_val4), .out_rdy(out_rdy4), .out_msg(out_msg4),
    .out_ovf(out_ovf4), .occupancy(occupancy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Reference: the whole pipe adds nst*incr; overflow means the running sum ever crossed 2^NB.
  function automatic logic [NB:0] modelOut(input int inVal, input int nst, input int incr);
    int   total;
    int   msg;
    logic ovf;
    total = inVal + nst * incr;
    ovf   = (total >= 2**NB);
`ifdef REGINCR_PIPE_SAT_EN
    msg = ovf ? (2**NB - 1) : total;
`else
    msg = total % (2**NB);
`endif
    return {ovf, NB'(msg)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy and in_rdy follow from the number of messages in flight; outputs pop the queue.
  always @(negedge clk) begin
    exp_t          e;
    logic [NB:0]   r;
    if (reset) begin
      holdValid = 1'b0;
    end else begin
      checkOutput("occupancy", 32'(occupancy), 32'(q.size()));
      checkOutput("in_rdy", 32'(in_rdy), 32'((q.size() < NS) || out_rdy));
      if (holdValid) begin
        checkOutput("stalled out_val", 32'(out_val), 32'd1);
        checkOutput("stalled out_msg", 32'(out_msg), 32'(holdMsg));
        checkOutput("stalled out_ovf", 32'(out_ovf), 32'(holdOvf));
      end
      if (out_val && out_rdy) begin
        outCnt++;
        if (q.size() == 0) begin
          checkOutput("output with empty scoreboard", 32'(out_val), 32'd0);
        end else begin
          e = q.pop_front();
          checkOutput("out_msg", 32'(out_msg), 32'(e.msg));
          checkOutput("out_ovf", 32'(out_ovf), 32'(e.ovf));
          if (e.lat)
            checkOutput("latency", 32'(cycle - e.cyc), 32'(NS));
        end
      end
      if (in_val && in_rdy) begin
        inCnt++;
        r = modelOut(int'(in_msg), NS, INC);
        q.push_back('{msg: r[NB-1:0], ovf: r[NB], cyc: cycle, lat: chkLat});
      end
      holdValid = out_val && !out_rdy;
      holdMsg   = out_msg;
      holdOvf   = out_ovf;
    end
  end

  // Called just after a rising edge; holds in_val until the message is taken or the budget runs out.
  task automatic applyStimulus(input logic [NB-1:0] msg);
    bit acc;
    acc    = 1'b0;
    in_val = 1'b1;
    in_msg = msg;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    checkOutput("input accepted", 32'(acc), 32'd1);
  endtask

  task automatic waitDrain();
    out_rdy = 1'b1;
    in_val  = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++)
      @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("drained", 32'(q.size()), 32'd0);
  endtask

  task automatic runD4(input logic [NB-1:0] msg);
    logic [NB:0] r;
    r       = modelOut(int'(msg), NS4, INC4);
    in_val4 = 1'b1;
    in_msg4 = msg;
    @(negedge clk);
    checkOutput("deep in_rdy", 32'(in_rdy4), 32'd1);
    @(posedge clk);
    #1;
    in_val4 = 1'b0;
    for (int k = 1; k <= NS4; k++) begin
      @(negedge clk);
      if (k < NS4) begin
        checkOutput("deep early out_val", 32'(out_val4), 32'd0);
      end else begin
        checkOutput("deep out_val", 32'(out_val4), 32'd1);
        checkOutput("deep out_msg", 32'(out_msg4), 32'(r[NB-1:0]));
        checkOutput("deep out_ovf", 32'(out_ovf4), 32'(r[NB]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no summary, expected one");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int i0;
    int o0;

    #2 reset = 1'b1;
    #1;
    checkOutput("reset out_val", 32'(out_val), 32'd0);
    checkOutput("reset out_msg", 32'(out_msg), 32'd0);
    checkOutput("reset out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("reset occupancy", 32'(occupancy), 32'd0);
    checkOutput("reset in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("reset deep occupancy", 32'(occupancy4), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back stream");
    chkLat = 1'b1;
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h7f);
    waitDrain();

    $display("[TB] overflow values");
    applyStimulus(8'hff);
    applyStimulus(8'hfe);
    waitDrain();

    $display("[TB] stalled output");
    chkLat  = 1'b0;
    out_rdy = 1'b0;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    in_val = 1'b1;
    in_msg = 8'h03;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("full in_rdy", 32'(in_rdy), 32'd0);
      checkOutput("full occupancy", 32'(occupancy), 32'd2);
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    applyStimulus(8'h03);
    waitDrain();

    $display("[TB] full pipe streaming");
    out_rdy = 1'b0;
    applyStimulus(NB'($urandom));
    applyStimulus(NB'($urandom));
    i0 = inCnt;
    o0 = outCnt;
    out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_val = 1'b1;
      in_msg = NB'($urandom);
      @(posedge clk);
      #1;
    end
    checkOutput("streaming inputs", 32'(inCnt - i0), 32'd10);
    checkOutput("streaming outputs", 32'(outCnt - o0), 32'd10);
    checkOutput("streaming occupancy", 32'(occupancy), 32'd2);
    in_val = 1'b0;
    waitDrain();

    $display("[TB] reset with messages in flight");
    out_rdy = 1'b0;
    applyStimulus(8'h40);
    applyStimulus(8'h41);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-reset out_val", 32'(out_val), 32'd0);
    checkOutput("mid-reset occupancy", 32'(occupancy), 32'd0);
    checkOutput("mid-reset in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("mid-reset out_msg", 32'(out_msg), 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    chkLat  = 1'b1;
    applyStimulus(8'h20);
    waitDrain();

    $display("[TB] random traffic");
    chkLat = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_val  = 1'($urandom_range(0, 1));
      in_msg  = NB'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    waitDrain();

    $display("[TB] deep pipe");
    runD4(8'h05);
    runD4(8'hf8);
    runD4(NB'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
